tpu_sequencer: RTL and testbench
================================

# tpu_sequencer

Parametrised instruction sequencer for the TPU. It fetches instructions from a synchronous instruction memory using its own program counter, decodes them, and drives the datapath control strobes: `load_weight`, `load_input`, `valid` and `store`, plus `base_address`. It adds program flow (JUMP, HALT), multi-cycle compute bursts and a datapath stall handshake. It sits between the instruction memory and the systolic array / unified buffer control inputs.

## Interface
Parameters:
- `INSTR_W`, 16, instruction width.
- `OP_W`, 3, opcode width; opcode = `instr[INSTR_W-1 -: OP_W]`; operand = `instr[INSTR_W-OP_W-1:0]`.
- `PC_W`, 8, program counter / instruction memory address width.
- `CNT_W`, 8, compute burst count field width; required `CNT_W <= INSTR_W-OP_W`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin execution at PC 0; honoured only in IDLE or HALTED.
- `imem_addr`  out  PC_W  instruction memory address; equals the PC register.
- `imem_rdata`  in  INSTR_W  instruction word, valid one cycle after `imem_addr`.
- `dp_busy`  in  1  datapath stall; blocks issue while high.
- `base_address`  out  INSTR_W-OP_W  registered base address.
- `load_weight`, `load_input`, `store`  out  1 each  one-cycle registered strobes.
- `valid`  out  1  registered compute enable; may be high for multiple cycles.
- `busy`  out  1  high in FETCH, EXEC and COMPUTE.
- `halted`  out  1  high in HALTED.

## Operation
States: IDLE, FETCH, EXEC, COMPUTE, HALTED.
- IDLE: `start` sets PC to 0 and moves to FETCH.
- FETCH: one cycle, with `imem_addr` = PC. Always moves to EXEC.
- EXEC with `dp_busy`=1: stall. State, PC and outputs hold; no strobe is issued.
- EXEC with `dp_busy`=0: issue the instruction in `imem_rdata` according to the opcode table below.
- COMPUTE: `valid` stays high while the remaining count is greater than 0; moves to FETCH on the last valid cycle. `dp_busy` is ignored.
- HALTED: `halted`=1. `start` sets PC to 0 and moves to FETCH.

Opcodes. Each issues in EXEC. PC becomes PC+1 (wrapping modulo 2^PC_W) unless noted, and the next state is FETCH unless noted.
- 000 NOP: no strobe.
- 001 LOAD_ADDR: `base_address` takes the operand.
- 010 LOAD_WEIGHT: pulse `load_weight`.
- 011 LOAD_INPUTS: pulse `load_input`.
- 100 VALID: N = `operand[CNT_W-1:0]`, with 0 treated as 1. `valid` is high for exactly N cycles. Next state is COMPUTE if N>1, otherwise FETCH.
- 101 STORE: pulse `store`.
- 110 JUMP: PC takes `operand[PC_W-1:0]`; no strobe.
- 111 HALT: PC holds; next state is HALTED.

Opcode values outside this table when `OP_W` > 3 decode as NOP.

Other rules:
- `base_address` holds its value across HALT, `start` and stalls. Only LOAD_ADDR and reset change it.
- `start` in FETCH, EXEC or COMPUTE is ignored.

## Timing
- Reset values: state IDLE, PC 0, `base_address` 0, all strobes 0, `valid` 0, `busy` 0, `halted` 0.
- Reset asserted in any state, including mid-COMPUTE, forces these values on the next edge. A burst in progress is dropped.
- Instruction memory read latency is exactly 1 cycle. The sequencer never changes `imem_addr` during a stall, so `imem_rdata` stays stable.
- Let E be the issue cycle (the EXEC cycle with `dp_busy`=0).
  - Strobes and `base_address` update are visible in cycle E+1 only (for `base_address`, from E+1 on).
  - `imem_addr` shows the new PC at E+1.
  - Next FETCH is E+1; next EXEC is E+2.
  - Throughput without stalls is one instruction per 2 cycles.
- VALID issued at E: `valid` is high in cycles E+1 .. E+N. The next FETCH is cycle E+N; the next EXEC is E+N+1.
- A `start` sampled at cycle S makes S+1 the FETCH of address 0; the first possible strobe is at S+3.
- HALT at E: `busy`=0 and `halted`=1 from E+1.
- PC wrap: PC = 2^PC_W − 1 followed by a non-JUMP, non-HALT instruction gives PC = 0.

## Test plan
- Reset then `start` with program [001 operand 0x0A5, 010, 011, 101, 111] -> `base_address`=0x0A5; `load_weight`, `load_input` and `store` each high for exactly 1 cycle, 2 cycles apart; `halted`=1; PC stays at 4.
- VALID with count 5, then VALID with count 0 -> `valid` high for 5 consecutive cycles, then high for 1 cycle. The second EXEC starts 6 cycles after the first EXEC.
- `dp_busy` held high for 3 cycles during EXEC of a LOAD_WEIGHT -> no strobe during the stall, `imem_addr` constant, strobe exactly one cycle after `dp_busy` falls.
- JUMP to 0x10 at address 3, with HALT at 0x10 -> `imem_addr` sequence 0,1,2,3,0x10, then `halted`; addresses 4..0x0F never fetched.
- Program of NOPs spanning address 0xFF (PC_W=8) -> PC wraps to 0x00.
- `reset` asserted at the 2nd cycle of a VALID burst with count 8 -> `valid`=0, `busy`=0 and `base_address`=0 on the next cycle; `start` afterwards restarts fetch from 0.

Source files
------------

// File: rtl/tpu_sequencer.sv
// tpu_sequencer
// Fetches instructions from a synchronous instruction memory (1-cycle read
// latency) using its own PC, decodes them and drives the datapath control
// strobes for the systolic array / unified buffer.
//
// Ports
//   i_clk           clock, all state changes on rising edge
//   i_reset         synchronous active-high reset
//   i_start         begin execution at PC 0 (honoured in IDLE / HALTED only)
//   o_imem_addr     instruction memory address (= PC register)
//   i_imem_rdata    instruction word, valid one cycle after o_imem_addr
//   i_dp_busy       datapath stall, blocks issue in EXEC
//   o_base_address  registered base address (set by LOAD_ADDR)
//   o_load_weight   one-cycle strobe
//   o_load_input    one-cycle strobe
//   o_store         one-cycle strobe
//   o_valid         compute enable, high for N cycles per VALID instruction
//   o_busy          high in FETCH, EXEC and COMPUTE
//   o_halted        high in HALTED
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | out of reset, waiting for start
// S_FETCH   | imem_addr = PC, instruction word arrives next cycle
// S_EXEC    | decode/issue imem_rdata; holds while dp_busy is high
// S_COMPUTE | remainder of a multi-cycle VALID burst
// S_HALTED  | HALT executed, waiting for start

module tpu_sequencer #(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 3,
  parameter int PC_W    = 8,
  parameter int CNT_W   = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic [PC_W-1:0]           o_imem_addr,
  input  logic [INSTR_W-1:0]        i_imem_rdata,
  input  logic                      i_dp_busy,
  output logic [INSTR_W-OP_W-1:0]   o_base_address,
  output logic                      o_load_weight,
  output logic                      o_load_input,
  output logic                      o_store,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_halted
);

  localparam int OPND_W = INSTR_W - OP_W;

  localparam logic [OP_W-1:0] OP_LOAD_ADDR   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD_WEIGHT = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD_INPUTS = OP_W'(3);
  localparam logic [OP_W-1:0] OP_VALID       = OP_W'(4);
  localparam logic [OP_W-1:0] OP_STORE       = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JUMP        = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HALT        = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_COMPUTE,
    S_HALTED
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [OPND_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_load_weight;
  logic                r_load_input;
  logic                r_store;
  logic                r_valid;

  state_t              w_state_nxt;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [OPND_W-1:0]   w_base_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_load_weight_nxt;
  logic                w_load_input_nxt;
  logic                w_store_nxt;
  logic                w_valid_nxt;

  logic [OP_W-1:0]     w_op;
  logic [OPND_W-1:0]   w_opnd;
  logic [CNT_W-1:0]    w_burst;

  assign w_op   = i_imem_rdata[INSTR_W-1 -: OP_W];
  assign w_opnd = i_imem_rdata[OPND_W-1:0];
  // A burst count of 0 behaves like 1.
  assign w_burst = (w_opnd[CNT_W-1:0] == '0) ? CNT_W'(1) : w_opnd[CNT_W-1:0];

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_base_nxt        = r_base;
    w_cnt_nxt         = r_cnt;
    w_load_weight_nxt = 1'b0;
    w_load_input_nxt  = 1'b0;
    w_store_nxt       = 1'b0;
    w_valid_nxt       = 1'b0;

    case (r_state)
      S_IDLE, S_HALTED: begin
        if (i_start) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        if (!i_dp_busy) begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = S_FETCH;
          case (w_op)
            OP_LOAD_ADDR:   w_base_nxt        = w_opnd;
            OP_LOAD_WEIGHT: w_load_weight_nxt = 1'b1;
            OP_LOAD_INPUTS: w_load_input_nxt  = 1'b1;
            OP_STORE:       w_store_nxt       = 1'b1;
            OP_JUMP:        w_pc_nxt          = w_opnd[PC_W-1:0];
            OP_HALT: begin
              w_pc_nxt    = r_pc;
              w_state_nxt = S_HALTED;
            end
            OP_VALID: begin
              w_valid_nxt = 1'b1;
              // r_cnt holds the valid cycles still owed after the first one.
              if (w_burst > CNT_W'(1)) begin
                w_cnt_nxt   = w_burst - CNT_W'(1);
                w_state_nxt = S_COMPUTE;
              end
            end
            default: ;
          endcase
        end
      end

      S_COMPUTE: begin
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        // Leave on the edge that launches the last valid cycle, so FETCH
        // overlaps it.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_base        <= '0;
      r_cnt         <= '0;
      r_load_weight <= 1'b0;
      r_load_input  <= 1'b0;
      r_store       <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_base        <= w_base_nxt;
      r_cnt         <= w_cnt_nxt;
      r_load_weight <= w_load_weight_nxt;
      r_load_input  <= w_load_input_nxt;
      r_store       <= w_store_nxt;
      r_valid       <= w_valid_nxt;
    end
  end

  assign o_imem_addr    = r_pc;
  assign o_base_address = r_base;
  assign o_load_weight  = r_load_weight;
  assign o_load_input   = r_load_input;
  assign o_store        = r_store;
  assign o_valid        = r_valid;
  assign o_busy         = (r_state == S_FETCH) || (r_state == S_EXEC) ||
                          (r_state == S_COMPUTE);
  assign o_halted       = (r_state == S_HALTED);

endmodule

// File: tb/tb_tpu_sequencer.sv
// Testbench for tpu_sequencer: behavioural instruction memory, an event
// scoreboard for strobes/valid (expected cycle offsets from start), and
// direct checks of address, base, busy and halted at chosen cycles.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dp_busy;
  logic [12:0] base_address;
  logic        load_weight, load_input, store, valid, busy, halted;

  logic [15:0] mem [256];
  logic [31:0] sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  localparam logic [2:0] NOP = 3'd0, LDA = 3'd1, LDW = 3'd2, LDI = 3'd3,
                         VAL = 3'd4, STO = 3'd5, JMP = 3'd6, HLT = 3'd7;
  localparam int EV_LW = 1, EV_LI = 2, EV_ST = 3, EV_VAL = 4;

  tpu_sequencer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .o_imem_addr    (imem_addr),
    .i_imem_rdata   (imem_rdata),
    .i_dp_busy      (dp_busy),
    .o_base_address (base_address),
    .o_load_weight  (load_weight),
    .o_load_input   (load_input),
    .o_store        (store),
    .o_valid        (valid),
    .o_busy         (busy),
    .o_halted       (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= mem[imem_addr];
    cyc        <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d after start)", tag, got, exp, cyc - t0);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] opnd);
    return {op, opnd};
  endfunction

  task automatic exp_ev(input int kind, input int k);
    sb_q.push_back({kind[15:0], k[15:0]});
  endtask

  task automatic sb_pop(input int kind);
    logic [31:0] got;
    int rel;
    rel = cyc - t0;
    got = {kind[15:0], rel[15:0]};
    if (sb_q.size() == 0) chk("sb_unexpected", got, 32'd0);
    else                  chk("sb_event", got, sb_q.pop_front());
  endtask

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (load_weight === 1'b1) sb_pop(EV_LW);
    if (load_input  === 1'b1) sb_pop(EV_LI);
    if (store       === 1'b1) sb_pop(EV_ST);
    if (valid       === 1'b1) sb_pop(EV_VAL);
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Raise start for one cycle; that cycle becomes offset 0 (cycle S).
  task automatic do_start();
    @(negedge clk);
    t0    = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic at(input int k);
    while (cyc != t0 + k) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    dp_busy = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_base", 32'(base_address), 32'd0);
    chk("rst_flags", {valid, busy, halted, load_weight, load_input, store}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Test 1: basic program
    clear_mem();
    mem[0] = mk(LDA, 13'h0A5);
    mem[1] = mk(LDW, 13'h0);
    mem[2] = mk(LDI, 13'h0);
    mem[3] = mk(STO, 13'h0);
    mem[4] = mk(HLT, 13'h0);
    exp_ev(EV_LW, 5); exp_ev(EV_LI, 7); exp_ev(EV_ST, 9);
    do_start();
    at(1);  chk("t1_busy_fetch", 32'(busy), 32'd1);
    at(2);  chk("t1_base_pre", 32'(base_address), 32'd0);
    at(3);  chk("t1_base", 32'(base_address), 32'h0A5);
    at(10); chk("t1_halted_pre", 32'(halted), 32'd0);
    at(11); chk("t1_halted", 32'(halted), 32'd1);
            chk("t1_busy", 32'(busy), 32'd0);
    at(14); chk("t1_pc_hold", 32'(imem_addr), 32'd4);

    // Test 2: VALID 5 then VALID 0
    clear_mem();
    mem[0] = mk(VAL, 13'd5);
    mem[1] = mk(VAL, 13'd0);
    mem[2] = mk(HLT, 13'h0);
    for (int k = 3; k <= 7; k++) exp_ev(EV_VAL, k);
    exp_ev(EV_VAL, 9);
    do_start();
    at(11); chk("t2_halted", 32'(halted), 32'd1);
            chk("t2_pc", 32'(imem_addr), 32'd2);
            chk("t2_base_kept", 32'(base_address), 32'h0A5);

    // Test 3: stall during EXEC of LOAD_WEIGHT
    clear_mem();
    mem[0] = mk(LDW, 13'h0);
    mem[1] = mk(HLT, 13'h0);
    exp_ev(EV_LW, 6);
    do_start();
    at(2); dp_busy = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      at(k);
      chk("t3_stall_addr", 32'(imem_addr), 32'd0);
      chk("t3_stall_busy", 32'(busy), 32'd1);
    end
    at(5); dp_busy = 1'b0;
    chk("t3_issue_addr", 32'(imem_addr), 32'd0);
    at(6); chk("t3_addr_after", 32'(imem_addr), 32'd1);
    at(8); chk("t3_halted", 32'(halted), 32'd1);

    // Test 4: JUMP skips 4..0x0F (filled with STORE)
    clear_mem();
    mem[3]  = mk(JMP, 13'h010);
    for (int i = 4; i < 16; i++) mem[i] = mk(STO, 13'h0);
    mem[16] = mk(HLT, 13'h0);
    do_start();
    for (int k = 1; k <= 12; k++) begin
      int ea;
      at(k);
      ea = (k <= 8) ? (k - 1) / 2 : 16;
      chk("t4_addr", 32'(imem_addr), 32'(ea));
    end
    chk("t4_halted", 32'(halted), 32'd1);

    // Test 5: PC wrap 0xFF -> 0x00
    clear_mem();
    mem[0]   = mk(JMP, 13'h0FE);
    mem[255] = mk(LDW, 13'h0);
    exp_ev(EV_LW, 7);
    do_start();
    at(3); chk("t5_addr_fe", 32'(imem_addr), 32'h0FE);
    mem[0] = mk(HLT, 13'h0);
    at(5); chk("t5_addr_ff", 32'(imem_addr), 32'h0FF);
    at(7); chk("t5_wrap", 32'(imem_addr), 32'h000);
    at(9); chk("t5_halted", 32'(halted), 32'd1);
           chk("t5_pc_hold", 32'(imem_addr), 32'h000);

    // Test 6: reset in the 2nd cycle of a VALID 8 burst
    clear_mem();
    mem[0] = mk(LDA, 13'h055);
    mem[1] = mk(VAL, 13'd8);
    mem[2] = mk(HLT, 13'h0);
    exp_ev(EV_VAL, 5); exp_ev(EV_VAL, 6);
    do_start();
    at(5); chk("t6_base_set", 32'(base_address), 32'h055);
    at(6); reset = 1'b1;
    at(7); reset = 1'b0;
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_base", 32'(base_address), 32'd0);
    chk("t6_rst_addr", 32'(imem_addr), 32'd0);
    at(9); chk("t6_idle_stays", 32'(busy), 32'd0);
    for (int k = 5; k <= 12; k++) exp_ev(EV_VAL, k);
    do_start();
    at(1);  chk("t6_restart_addr", 32'(imem_addr), 32'd0);
            chk("t6_restart_busy", 32'(busy), 32'd1);
    at(14); chk("t6_halted", 32'(halted), 32'd1);
            chk("t6_base_final", 32'(base_address), 32'h055);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
